// File: rtl/vector_pkg.sv
// Shared definitions for the vector buffer read path: data width and
// the arbiter transaction FSM encoding.
package vector_pkg;

  localparam int VEC_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/vector_arbiter_rr_picker.sv
// Combinational round-robin pick: first requesting index at or above ptr,
// wrapping modulo NB_CLIENTS.
module rr_picker #(
  parameter int NB_CLIENTS = 4,
  parameter int IDX_W      = $clog2(NB_CLIENTS)
) (
  input  logic [NB_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic [IDX_W-1:0]      grant,
  output logic                  any
);

  logic [IDX_W:0]          rot_idx [NB_CLIENTS];
  logic [NB_CLIENTS-1:0]   rot_req;

  // Candidate index for each offset from ptr; one extra bit so the sum
  // never overflows and the wrap is an explicit subtraction.
  generate
    for (genvar gi = 0; gi < NB_CLIENTS; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign rot_idx[gi]  = (sum >= (IDX_W+1)'(NB_CLIENTS)) ?
                            sum - (IDX_W+1)'(NB_CLIENTS) : sum;
      assign rot_req[gi]  = req[rot_idx[gi][IDX_W-1:0]];
    end
  endgenerate

  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = NB_CLIENTS - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        grant = rot_idx[i][IDX_W-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_arbiter.sv
// Round-robin arbiter sharing the vector_buffer read port among
// NB_CLIENTS consumers, one 4-cycle transaction at a time.
module vector_arbiter #(
  parameter int NB_CLIENTS = 4,
  parameter int VEC_W      = vector_pkg::VEC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NB_CLIENTS-1:0] client_req,
  output logic [NB_CLIENTS-1:0] client_ack,
  output logic [NB_CLIENTS-1:0] client_nack,
  output logic [VEC_W-1:0]      client_vector,
  output logic                  buf_req,
  input  logic [VEC_W-1:0]      buf_vector,
  input  logic                  buf_valid,
  output logic [7:0]            nack_count
);

  import vector_pkg::*;

  localparam int IDX_W = $clog2(NB_CLIENTS);

  arb_state_e            state_q;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      grant_q;
  logic                  buf_req_q;
  logic [NB_CLIENTS-1:0] ack_q, nack_q, grant_oh_d;
  logic [VEC_W-1:0]      vec_q;
  logic [7:0]            nack_cnt_q;

  logic [IDX_W-1:0]      pick_grant;
  logic                  pick_any;

  rr_picker #(
    .NB_CLIENTS (NB_CLIENTS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req   (client_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  assign ptr_d      = (grant_q == IDX_W'(NB_CLIENTS - 1)) ? '0 : grant_q + IDX_W'(1);
  assign grant_oh_d = NB_CLIENTS'(1) << grant_q;

  // Async reset also clears buf_req immediately so no read is issued
  // while the block is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      buf_req_q  <= 1'b0;
      ack_q      <= '0;
      nack_q     <= '0;
      vec_q      <= '0;
      nack_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q   <= pick_grant;
            buf_req_q <= 1'b1;
            state_q   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          buf_req_q <= 1'b0;
          state_q   <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (buf_valid) begin
            vec_q <= buf_vector;
            ack_q <= grant_oh_d;
          end else begin
            nack_q <= grant_oh_d;
            if (nack_cnt_q != 8'hFF) nack_cnt_q <= nack_cnt_q + 8'd1;
          end
          state_q <= ARB_RESP;
        end
        ARB_RESP: begin
          ack_q   <= '0;
          nack_q  <= '0;
          vec_q   <= '0;
          ptr_q   <= ptr_d;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign buf_req       = buf_req_q;
  assign client_ack    = ack_q;
  assign client_nack   = nack_q;
  assign client_vector = vec_q;
  assign nack_count    = nack_cnt_q;

endmodule

// File: tb/tb_vector_arbiter.sv
// Bench for vector_arbiter: two configurations (4 and 3 clients) checked
// cycle by cycle against a transaction-level model with a queue-based buffer.
module tb_vector_arbiter;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  bit done [2];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int NBC = (gi == 0) ? 4 : 3;
      localparam int ALL = (1 << NBC) - 1;

      logic           rst_n;
      logic [NBC-1:0] client_req;
      logic [NBC-1:0] client_ack;
      logic [NBC-1:0] client_nack;
      logic [7:0]     client_vector;
      logic           buf_req;
      logic [7:0]     buf_vector;
      logic           buf_valid;
      logic [7:0]     nack_count;

      vector_arbiter #(.NB_CLIENTS(NBC), .VEC_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .client_req    (client_req),
        .client_ack    (client_ack),
        .client_nack   (client_nack),
        .client_vector (client_vector),
        .buf_req       (buf_req),
        .buf_vector    (buf_vector),
        .buf_valid     (buf_valid),
        .nack_count    (nack_count)
      );

      // Buffer environment: pops on a sampled read strobe, otherwise
      // presents garbage so mistimed capture is visible.
      int unsigned buf_q [$];
      always @(posedge clk) begin
        if (buf_req) begin
          if (buf_q.size() > 0) begin
            buf_valid  <= 1'b1;
            buf_vector <= 8'(buf_q.pop_front());
          end else begin
            buf_valid  <= 1'b0;
            buf_vector <= 8'h00;
          end
        end else begin
          buf_valid  <= 1'($urandom);
          buf_vector <= 8'($urandom);
        end
      end

      // Reference model state (transaction level)
      int unsigned ref_q [$];
      int cyc, req_at, resp_at, next_free;
      int m_ptr, m_grant, m_valid, m_vec, m_nacks;

      task automatic push(input int v);
        buf_q.push_back(v & 8'hFF);
        ref_q.push_back(v & 8'hFF);
      endtask

      task automatic step(input int mask);
        bit resp;
        int exp_ack, exp_nack, exp_vec;
        resp = (cyc == resp_at);
        if (resp && m_valid == 0 && m_nacks < 255) m_nacks++;
        exp_ack  = (resp && m_valid != 0) ? (1 << m_grant) : 0;
        exp_nack = (resp && m_valid == 0) ? (1 << m_grant) : 0;
        exp_vec  = (resp && m_valid != 0) ? m_vec : 0;
        check($sformatf("cfg%0d c%0d buf_req", gi, cyc), int'(buf_req), int'(cyc == req_at));
        check($sformatf("cfg%0d c%0d ack", gi, cyc), int'(client_ack), exp_ack);
        check($sformatf("cfg%0d c%0d nack", gi, cyc), int'(client_nack), exp_nack);
        check($sformatf("cfg%0d c%0d vector", gi, cyc), int'(client_vector), exp_vec);
        check($sformatf("cfg%0d c%0d nack_count", gi, cyc), int'(nack_count), m_nacks);
        if (resp)
          $display("cfg%0d txn cycle=%0d grant=%0d %s vec=0x%02h nacks=%0d",
                   gi, cyc, m_grant, (m_valid != 0) ? "ack" : "nack", m_vec, m_nacks);
        client_req = NBC'(mask);
        if (cyc >= next_free && (mask & ALL) != 0) begin
          for (int k = 0; k < NBC; k++) begin
            int idx;
            idx = (m_ptr + k) % NBC;
            if (mask[idx]) begin
              m_grant = idx;
              break;
            end
          end
          if (ref_q.size() > 0) begin
            m_valid = 1;
            m_vec   = int'(ref_q.pop_front());
          end else begin
            m_valid = 0;
            m_vec   = 0;
          end
          req_at    = cyc + 1;
          resp_at   = cyc + 3;
          next_free = cyc + 4;
          m_ptr     = (m_grant + 1) % NBC;
        end
        @(negedge clk);
        cyc++;
      endtask

      // Assert reset while the model says the DUT is in ISSUE (0) or WAIT (1).
      task automatic reset_in(input int offset, input int mask);
        for (int g = 0; g < 12 && !(next_free > cyc && cyc == req_at + offset); g++)
          step(mask);
        check($sformatf("cfg%0d reset_reach%0d", gi, offset),
              int'(next_free > cyc && cyc == req_at + offset), 1);
        rst_n = 1'b0;
        #1;
        check($sformatf("cfg%0d rst%0d buf_req", gi, offset), int'(buf_req), 0);
        check($sformatf("cfg%0d rst%0d ack", gi, offset), int'(client_ack), 0);
        check($sformatf("cfg%0d rst%0d nack", gi, offset), int'(client_nack), 0);
        check($sformatf("cfg%0d rst%0d vector", gi, offset), int'(client_vector), 0);
        check($sformatf("cfg%0d rst%0d nack_count", gi, offset), int'(nack_count), 0);
        if (offset == 0 && m_valid != 0) ref_q.push_front(m_vec);
        m_ptr   = 0;
        m_nacks = 0;
        req_at  = -100;
        resp_at = -100;
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        next_free = cyc;
      endtask

      initial begin
        rst_n = 1'b0;
        client_req = '0;
        cyc = 0; req_at = -100; resp_at = -100; next_free = 0;
        m_ptr = 0; m_grant = 0; m_valid = 0; m_vec = 0; m_nacks = 0;
        repeat (2) @(negedge clk);
        check($sformatf("cfg%0d reset buf_req", gi), int'(buf_req), 0);
        check($sformatf("cfg%0d reset ack", gi), int'(client_ack), 0);
        check($sformatf("cfg%0d reset nack", gi), int'(client_nack), 0);
        check($sformatf("cfg%0d reset vector", gi), int'(client_vector), 0);
        check($sformatf("cfg%0d reset nack_count", gi), int'(nack_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single client 2 reads 0xA5
        push(8'hA5);
        repeat (4) step(3'b100);
        step(0);
        // empty buffer, client 0
        repeat (4) step(1);
        step(0);
        // all clients hold requests, buffer holds 1..8
        for (int v = 1; v <= 8; v++) push(v);
        repeat (32) step(ALL);
        step(0);
        // client 1 drops its request mid-transaction
        push(8'h3C);
        push(8'h4D);
        step(3'b110);
        step(3'b110);
        step(3'b100);
        repeat (5) step(3'b100);
        step(0);
        // long run of empty reads saturates the nack counter
        repeat (1220) step(1);
        step(0);
        check($sformatf("cfg%0d nack_sat", gi), int'(nack_count), 255);
        // reset in ISSUE, then in WAIT, then resume from ptr 0
        push(8'h77);
        reset_in(0, 3'b010);
        push(8'h88);
        reset_in(1, ALL);
        repeat (16) step(ALL);
        step(0);
        // clients 0 and 2 only
        repeat (20) step(3'b101);
        step(0);
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
          if (cyc >= next_free && $urandom_range(2) == 0) push(int'($urandom));
          step(int'($urandom) & ALL);
        end
        repeat (4) step(0);
        done[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin
    for (int t = 0; t < 60000 && !(done[0] && done[1]); t++) @(posedge clk);
    check("timeout", int'(done[0] && done[1]), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
